// File: rtl/sram_b_pkg.sv
// sram_b_pkg: shared definitions for the sram_b read streamer and its
// output FIFO. Holds the default memory geometry, the FIFO depth (which is
// also the read credit limit) and the streamer FSM state encoding.
package sram_b_pkg;

  localparam int unsigned SRAM_B_ABITS = 13;  // 8192-word memory
  localparam int unsigned SRAM_B_DBITS = 8;   // memory word width
  localparam int unsigned SRAM_B_LBITS = 14;  // burst length, 0..8192

  // Words buffered in the FIFO plus the one read in flight never exceed this.
  localparam int unsigned FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sram_b_skid_fifo.sv
// sram_b_skid_fifo: 3-entry synchronous FIFO holding {last, data} words
// returned by the memory until the downstream consumer takes them.
//   CLK, RST   clock and synchronous active-high reset (flushes contents)
//   push       write push_data this cycle (caller guarantees space)
//   push_data  {last flag, data word}
//   pop        consumer takes the head entry (ignored when empty)
//   head_data  oldest entry, meaningful while count != 0
//   count      number of stored entries, 0..3
module sram_b_skid_fifo
  import sram_b_pkg::*;
#(
  parameter int unsigned WIDTH = SRAM_B_DBITS + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  localparam logic [1:0] LAST_IDX = 2'(FIFO_DEPTH - 1);

  logic [WIDTH-1:0] slot_q [FIFO_DEPTH];
  logic [WIDTH-1:0] slot_d [FIFO_DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;

  // Pointers wrap at the depth, which is not a power of two.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : (p + 2'd1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && (count_q != 2'd0);
    if (push) begin
      slot_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_q   <= '{default: {WIDTH{1'b0}}};
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = slot_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/sram_b_rd_streamer.sv
// sram_b_rd_streamer: burst read initiator for an sram_b memory port 1.
// Accepts {req_addr, req_len}, issues one read per cycle on CE1/A1 while
// read credit allows, captures Q1 one cycle later into a 3-entry FIFO and
// streams the words out in order on out_valid/out_ready with out_last on the
// final word, then pulses done.
//   CLK, RST                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_addr, req_len             base word address, word count (0..8192)
//   out_valid/out_ready/out_data  output stream
//   out_last                      final word of the burst
//   done                          one-cycle completion pulse
//   CE1, A1, Q1                   memory read port (1-cycle read latency)
module sram_b_rd_streamer
  import sram_b_pkg::*;
#(
  parameter int unsigned ABITS = SRAM_B_ABITS,
  parameter int unsigned DBITS = SRAM_B_DBITS,
  parameter int unsigned LBITS = SRAM_B_LBITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [LBITS-1:0] req_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1
);

  localparam logic [LBITS-1:0] LEN_ONE    = {{(LBITS-1){1'b0}}, 1'b1};
  localparam logic [ABITS-1:0] ADDR_ONE   = {{(ABITS-1){1'b0}}, 1'b1};
  localparam logic [2:0]       CREDIT_MAX = 3'(FIFO_DEPTH);

  rd_state_e        state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [LBITS-1:0] len_q, len_d;
  logic [LBITS-1:0] issued_q, issued_d;
  logic [LBITS-1:0] ret_q, ret_d;      // words returned by the memory so far
  logic             inflight_q, inflight_d;

  logic [1:0]       fifo_count;
  logic [DBITS:0]   fifo_head;
  logic [DBITS:0]   fifo_push_data;
  logic             fifo_pop;
  logic [2:0]       credit;
  logic             issue;
  logic             head_valid;
  logic             final_hs;

  // Issue/credit and output-handshake decode. Credit uses registered state
  // only, so out_ready never reaches CE1 combinationally.
  always_comb begin
    credit         = {1'b0, fifo_count} + {2'b00, inflight_q};
    issue          = (state_q == ST_RUN) && (issued_q < len_q) &&
                     (credit < CREDIT_MAX) && !RST;
    head_valid     = (fifo_count != 2'd0) && !RST;
    fifo_pop       = head_valid && out_ready;
    final_hs       = fifo_pop && fifo_head[DBITS];
    // The last flag rides with the word so it stays stable under stall.
    fifo_push_data = {(ret_q == (len_q - LEN_ONE)), Q1};
  end

  // FSM next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    inflight_d = issue;
    if (inflight_q) begin
      ret_d = ret_q + LEN_ONE;
    end else begin
      ret_d = ret_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          len_d    = req_len;
          issued_d = {LBITS{1'b0}};
          ret_d    = {LBITS{1'b0}};
          state_d  = (req_len == {LBITS{1'b0}}) ? ST_FIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_ONE;  // wraps naturally at 2^ABITS
          issued_d = issued_q + LEN_ONE;
          if ((issued_q + LEN_ONE) == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (final_hs) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight read and returns to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ABITS{1'b0}};
      len_q      <= {LBITS{1'b0}};
      issued_q   <= {LBITS{1'b0}};
      ret_q      <= {LBITS{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      ret_q      <= ret_d;
      inflight_q <= inflight_d;
    end
  end

  // Q1 is valid exactly one cycle after an issue; credit guarantees room.
  sram_b_skid_fifo #(
    .WIDTH (DBITS + 1)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (inflight_q),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Output decode; all outputs read as zero while RST is high.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !RST;
    CE1       = issue;
    A1        = issue ? addr_q : {ABITS{1'b0}};
    out_valid = head_valid;
    out_data  = head_valid ? fifo_head[DBITS-1:0] : {DBITS{1'b0}};
    out_last  = head_valid && fifo_head[DBITS];
    done      = (state_q == ST_FIN) && !RST;
  end

endmodule
